// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   state_t       - arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   PORT_FETCH    - port id of the instruction-fetch requester
//   PORT_DATA     - port id of the data-access requester
//   is_bad_access - true when the memory cannot complete an access
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Writes must be word aligned. Reads of any alignment are allowed.
  // Every access needs a full word inside the memory, so the highest
  // legal byte address is mem_bytes - 4.
  function automatic logic is_bad_access(input logic        write,
                                         input logic [31:0] addr,
                                         input logic [31:0] mem_bytes);
    return (write && (addr[1:0] != 2'b00)) || (addr > (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the shared response
// bus and the command interface of the single-ported memory.
//   slave  - view taken by the arbiter
//   master - view taken by the requesters and the memory around it
interface mem_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic        req0_write;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_write;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;

  logic        resp0_valid;
  logic        resp1_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_cmd_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_ready;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_err, resp_rdata,
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rdata_ready
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_err, resp_rdata,
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata,
    output mem_cmd_ready, mem_rdata, mem_rdata_ready
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way grant selection for the memory arbiter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req0, req1  - request present on port 0 / port 1
//   update      - a grant was consumed this cycle; remember it
//   grant       - port id selected (meaningful when grant_valid)
//   grant_valid - at least one port is requesting
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic grant_valid
);

  logic last_grant;

  // last_grant resets to the data port so that the fetch port wins the
  // very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_DATA;
    end else if (update) begin
      last_grant <= grant;
    end
  end

  // On a tie the fetch port either always wins, or the port that was not
  // served last time gets its turn.
  always_comb begin
    grant_valid = req0 | req1;
    grant       = PORT_FETCH;
    if (req0 && req1) begin
      if (FIXED_PRIORITY != 0) begin
        grant = PORT_FETCH;
      end else begin
        grant = ~last_grant;
      end
    end else if (req1) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port
// (port 0) and the data port (port 1).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - requester handshakes, shared response bus, memory command
//   busy       - an access is in flight (FSM not idle)
// Accesses the memory cannot complete are answered with an error pulse one
// cycle after acceptance and never reach the memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          FIXED_PRIORITY = 0,
  parameter int unsigned MEM_BYTES      = 8192
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  state_t      state;
  state_t      state_next;
  logic        grant;
  logic        grant_valid;
  logic        accept;
  logic        bad_access;
  logic        done;
  logic        port_id;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  rr_arbiter2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (bus.req0_valid),
    .req1       (bus.req1_valid),
    .update     (accept),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // A request is only taken while idle and while the memory is idle, so a
  // memory left busy by a reset is simply waited out.
  assign accept         = (state == IDLE) && grant_valid && bus.mem_cmd_ready;
  assign bus.req0_ready = accept && (grant == PORT_FETCH);
  assign bus.req1_ready = accept && (grant == PORT_DATA);

  assign sel_write  = (grant == PORT_DATA) ? bus.req1_write : bus.req0_write;
  assign sel_addr   = (grant == PORT_DATA) ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata  = (grant == PORT_DATA) ? bus.req1_wdata : bus.req0_wdata;
  assign bad_access = is_bad_access(sel_write, sel_addr, 32'(MEM_BYTES));

  assign done = (state == WAIT) && bus.mem_cmd_ready && bus.mem_rdata_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The memory samples cmd_start on the edge that leaves ISSUE, and its
  // completion flags are only trusted from WAIT onwards.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !bad_access) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command and response registers. Response pulses and cmd_start default
  // low every cycle so they are single-cycle strobes; err and rdata hold
  // until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_id           <= PORT_FETCH;
      bus.mem_cmd_start <= 1'b0;
      bus.mem_cmd_write <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.resp0_valid   <= 1'b0;
      bus.resp1_valid   <= 1'b0;
      bus.resp_err      <= 1'b0;
      bus.resp_rdata    <= '0;
    end else begin
      bus.mem_cmd_start <= 1'b0;
      bus.resp0_valid   <= 1'b0;
      bus.resp1_valid   <= 1'b0;
      if (accept) begin
        if (bad_access) begin
          bus.resp0_valid <= (grant == PORT_FETCH);
          bus.resp1_valid <= (grant == PORT_DATA);
          bus.resp_err    <= 1'b1;
          bus.resp_rdata  <= '0;
        end else begin
          port_id           <= grant;
          bus.mem_cmd_start <= 1'b1;
          bus.mem_cmd_write <= sel_write;
          bus.mem_addr      <= sel_addr;
          bus.mem_wdata     <= sel_wdata;
        end
      end
      if (done) begin
        bus.resp0_valid <= (port_id == PORT_FETCH);
        bus.resp1_valid <= (port_id == PORT_DATA);
        bus.resp_err    <= 1'b0;
        bus.resp_rdata  <= bus.mem_cmd_write ? 32'd0 : bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (round-robin and fixed priority), each in
// front of a behavioural model of the Memory block. The round-robin one is
// checked by a scoreboard fed from a byte-array reference of memory
// contents; the fixed-priority one only has its grant pattern counted.
module tb_mem_arbiter;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] busy;

  int         checks      = 0;
  int         errors      = 0;
  int         cycle_cnt   = 0;
  int         overlap_cnt = 0;
  int         cmd_cnt     = 0;
  int         fp_resp0    = 0;
  int         fp_resp1    = 0;
  exp_t       exp_q[$];
  int         grant_log[$];
  logic [7:0] ref_bytes [0:8191];

  mem_arbiter_if bus [2] ();

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Power-on contents of the memory, as a function of the word index.
  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    return {v[15:0] ^ 16'h5A00, v[15:0] ^ 16'hC3A5};
  endfunction

  // Memory model: aligned accesses complete on the edge that takes the
  // command; a misaligned read needs a second cycle during which the
  // memory reports itself busy.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        m_cmd_ready   = 1'b1;
    logic        m_rdata_ready = 1'b0;
    logic [31:0] m_rdata       = '0;
    logic        m_pend        = 1'b0;
    logic [31:0] m_pend_addr   = '0;
    logic        m_init_done   = 1'b0;
    logic [31:0] m_words [0:2047];
    logic [63:0] m_pair;

    assign bus[g].mem_cmd_ready   = m_cmd_ready;
    assign bus[g].mem_rdata_ready = m_rdata_ready;
    assign bus[g].mem_rdata       = m_rdata;
    assign m_pair = {m_words[m_pend_addr[12:2] + 11'd1], m_words[m_pend_addr[12:2]]};

    mem_arbiter #(
      .FIXED_PRIORITY(g),
      .MEM_BYTES     (8192)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus[g]),
      .busy (busy[g])
    );

    always @(posedge clk) begin
      if (!m_init_done) begin
        for (int i = 0; i < 2048; i++) m_words[i] <= init_word(i);
        m_init_done <= 1'b1;
      end else if (m_pend) begin
        m_rdata       <= 32'(m_pair >> (8 * m_pend_addr[1:0]));
        m_rdata_ready <= 1'b1;
        m_cmd_ready   <= 1'b1;
        m_pend        <= 1'b0;
      end else if (bus[g].mem_cmd_start && m_cmd_ready) begin
        if (bus[g].mem_cmd_write) begin
          m_words[bus[g].mem_addr[12:2]] <= bus[g].mem_wdata;
          m_rdata_ready                  <= 1'b1;
        end else if (bus[g].mem_addr[1:0] == 2'b00) begin
          m_rdata       <= m_words[bus[g].mem_addr[12:2]];
          m_rdata_ready <= 1'b1;
        end else begin
          m_pend        <= 1'b1;
          m_pend_addr   <= bus[g].mem_addr;
          m_cmd_ready   <= 1'b0;
          m_rdata_ready <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus[1].resp0_valid) fp_resp0 <= fp_resp0 + 1;
    if (bus[1].resp1_valid) fp_resp1 <= fp_resp1 + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: predicts each accepted request from the byte-array model
  // and compares each response pulse against the oldest prediction.
  initial begin : monitor
    logic [31:0] w;
    exp_t        e;
    logic        pv, pr, pw;
    logic [31:0] pa, pd;
    for (int a = 0; a < 8192; a++) begin
      w = init_word(a / 4);
      ref_bytes[a] = w[8*(a%4) +: 8];
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        continue;
      end
      if (bus[0].req0_ready && bus[0].req1_ready) overlap_cnt++;
      if (bus[0].mem_cmd_start) cmd_cnt++;
      if (bus[0].resp0_valid || bus[0].resp1_valid) begin
        if (bus[0].resp0_valid && bus[0].resp1_valid) checkOutput("resp_both_ports", 1, 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_port", bus[0].resp1_valid ? 1 : 0, e.port);
          checkOutput("resp_err", bus[0].resp_err, e.err);
          checkOutput("resp_rdata", bus[0].resp_rdata, e.rdata);
          checkOutput("resp_latency", cycle_cnt - e.acc + 1, e.lat);
        end
      end
      for (int p = 0; p < 2; p++) begin
        pv = (p == 0) ? bus[0].req0_valid : bus[0].req1_valid;
        pr = (p == 0) ? bus[0].req0_ready : bus[0].req1_ready;
        pw = (p == 0) ? bus[0].req0_write : bus[0].req1_write;
        pa = (p == 0) ? bus[0].req0_addr  : bus[0].req1_addr;
        pd = (p == 0) ? bus[0].req0_wdata : bus[0].req1_wdata;
        if (pv && pr) begin
          e.port  = p;
          e.acc   = cycle_cnt + 1;
          e.err   = 1'b0;
          e.rdata = '0;
          if ((pw && (pa % 4 != 0)) || ({1'b0, pa} + 33'd4 > 33'd8192)) begin
            e.err = 1'b1;
            e.lat = 1;
          end else if (pw) begin
            for (int k = 0; k < 4; k++) ref_bytes[pa + k] = pd[8*k +: 8];
            e.lat = 3;
          end else begin
            for (int k = 0; k < 4; k++) e.rdata[8*k +: 8] = ref_bytes[pa + k];
            e.lat = (pa % 4 == 0) ? 3 : 4;
          end
          exp_q.push_back(e);
          grant_log.push_back(p);
        end
      end
    end
  end

  // Drives one request on the round-robin instance and returns just after
  // the edge that accepted it, leaving valid high for the caller to drop.
  task automatic applyStimulus(input int port, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    if (port == 0) begin
      bus[0].req0_write = write;
      bus[0].req0_addr  = addr;
      bus[0].req0_wdata = wdata;
      bus[0].req0_valid = 1'b1;
    end else begin
      bus[0].req1_write = write;
      bus[0].req1_addr  = addr;
      bus[0].req1_wdata = wdata;
      bus[0].req1_valid = 1'b1;
    end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? bus[0].req0_ready : bus[0].req1_ready;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic releasePort(input int port);
    if (port == 0) bus[0].req0_valid = 1'b0;
    else           bus[0].req1_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic randomReq(output logic w, output logic [31:0] a, output logic [31:0] d);
    w = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       a = 32'd8189 + 32'($urandom_range(0, 20));
      1:       a = 32'($urandom_range(0, 8188));
      default: a = 32'($urandom_range(0, 2047)) << 2;
    endcase
    d = $urandom;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int fp_n0, fp_n1, n;
    rst_n = 1'b0;
    bus[0].req0_valid = 1'b0; bus[0].req0_write = 1'b0; bus[0].req0_addr = '0; bus[0].req0_wdata = '0;
    bus[0].req1_valid = 1'b0; bus[0].req1_write = 1'b0; bus[0].req1_addr = '0; bus[0].req1_wdata = '0;
    bus[1].req0_valid = 1'b0; bus[1].req0_write = 1'b0; bus[1].req0_addr = '0; bus[1].req0_wdata = '0;
    bus[1].req1_valid = 1'b0; bus[1].req1_write = 1'b0; bus[1].req1_addr = '0; bus[1].req1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_resp0_valid", bus[0].resp0_valid, 0);
    checkOutput("rst_resp1_valid", bus[0].resp1_valid, 0);
    checkOutput("rst_resp_err", bus[0].resp_err, 0);
    checkOutput("rst_resp_rdata", bus[0].resp_rdata, 0);
    checkOutput("rst_mem_cmd_start", bus[0].mem_cmd_start, 0);
    checkOutput("rst_mem_cmd_write", bus[0].mem_cmd_write, 0);
    checkOutput("rst_mem_addr", bus[0].mem_addr, 0);
    checkOutput("rst_mem_wdata", bus[0].mem_wdata, 0);
    checkOutput("rst_busy", busy[0], 0);
    checkOutput("rst_req0_ready", bus[0].req0_ready, 0);
    checkOutput("rst_req1_ready", bus[0].req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] round-robin with both ports always valid");
    fork
      begin
        logic w0; logic [31:0] a0, d0;
        for (int k = 0; k < 4; k++) begin
          randomReq(w0, a0, d0);
          applyStimulus(0, w0, a0, d0);
        end
        releasePort(0);
      end
      begin
        logic w1; logic [31:0] a1, d1;
        for (int k = 0; k < 4; k++) begin
          randomReq(w1, a1, d1);
          applyStimulus(1, w1, a1, d1);
        end
        releasePort(1);
      end
    join
    waitIdle();
    checkOutput("rr_grant_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      checkOutput($sformatf("rr_grant_%0d", k), grant_log[k], k % 2);

    $display("[TB] write then read back through different ports");
    applyStimulus(1, 1'b1, 32'h10, 32'h11223344);
    releasePort(1);
    waitIdle();
    checkOutput("wr_resp_err", bus[0].resp_err, 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    releasePort(0);
    waitIdle();
    checkOutput("rd_back_data", bus[0].resp_rdata, 32'h11223344);

    $display("[TB] rejected accesses and range boundary");
    n = cmd_cnt;
    applyStimulus(1, 1'b1, 32'h06, 32'hDEADBEEF);
    releasePort(1);
    waitIdle();
    checkOutput("misaligned_wr_err", bus[0].resp_err, 1);
    applyStimulus(1, 1'b0, 32'h1FFE, 32'h0);
    releasePort(1);
    waitIdle();
    checkOutput("range_rd_err", bus[0].resp_err, 1);
    applyStimulus(1, 1'b0, 32'h1FFD, 32'h0);
    releasePort(1);
    waitIdle();
    checkOutput("range_edge_plus1_err", bus[0].resp_err, 1);
    checkOutput("no_cmd_for_errors", cmd_cnt, n);
    applyStimulus(1, 1'b0, 32'h1FFC, 32'h0);
    releasePort(1);
    waitIdle();
    checkOutput("range_edge_err", bus[0].resp_err, 0);
    checkOutput("cmd_for_legal", cmd_cnt, n + 1);

    $display("[TB] misaligned read spanning two words");
    applyStimulus(0, 1'b1, 32'h04, 32'hDDCCBBAA);
    releasePort(0);
    waitIdle();
    applyStimulus(0, 1'b1, 32'h08, 32'h44332211);
    releasePort(0);
    waitIdle();
    applyStimulus(0, 1'b0, 32'h05, 32'h0);
    releasePort(0);
    waitIdle();
    checkOutput("misaligned_rd_err", bus[0].resp_err, 0);
    checkOutput("misaligned_rd_data", bus[0].resp_rdata, 32'h11DDCCBB);

    $display("[TB] fixed priority instance");
    bus[1].req0_addr = 32'h20;
    bus[1].req1_addr = 32'h24;
    bus[1].req0_valid = 1'b1;
    bus[1].req1_valid = 1'b1;
    fp_n0 = 0;
    fp_n1 = 0;
    for (int i = 0; i < 100 && fp_n0 < 4; i++) begin
      @(negedge clk);
      if (bus[1].req0_ready) fp_n0++;
      if (bus[1].req1_ready) fp_n1++;
    end
    @(posedge clk);
    #1;
    bus[1].req0_valid = 1'b0;
    bus[1].req1_valid = 1'b0;
    for (int i = 0; i < 40 && fp_resp0 < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("fp_port0_grants", fp_n0, 4);
    checkOutput("fp_port1_grants", fp_n1, 0);
    checkOutput("fp_port0_resps", fp_resp0, 4);
    checkOutput("fp_port1_resps", fp_resp1, 0);

    $display("[TB] reset while waiting on the memory");
    applyStimulus(0, 1'b0, 32'h09, 32'h0);
    releasePort(0);
    n = 0;
    while (!(busy[0] && !bus[0].mem_cmd_start) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("reach_wait_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_resp0_valid", bus[0].resp0_valid, 0);
    checkOutput("abort_resp1_valid", bus[0].resp1_valid, 0);
    checkOutput("abort_resp_err", bus[0].resp_err, 0);
    checkOutput("abort_resp_rdata", bus[0].resp_rdata, 0);
    checkOutput("abort_mem_cmd_start", bus[0].mem_cmd_start, 0);
    checkOutput("abort_mem_addr", bus[0].mem_addr, 0);
    checkOutput("abort_busy", busy[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    releasePort(0);
    waitIdle();
    checkOutput("after_abort_err", bus[0].resp_err, 0);
    checkOutput("after_abort_data", bus[0].resp_rdata, 32'h11223344);

    checkOutput("ready_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
